// File: rtl/log_arb_pkg.sv
// Shared types for the log memory write arbiter: FSM state encoding and
// requester indices used by the round-robin pointer.
package log_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_PREP  = 2'd1,
    GRANT_RECOV = 2'd2
  } arb_state_e;

  localparam logic REQ_PREP  = 1'b0;
  localparam logic REQ_RECOV = 1'b1;

endpackage

// File: rtl/log_ptr_tracker.sv
// Tail pointer and occupancy bookkeeping for the circular log memory.
// A write advances the tail and adds one beat; a free releases at most the
// beats currently held, so occupancy never underflows.
module log_ptr_tracker #(
  parameter int LOG_DEPTH_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_acc,
  input  logic                   free_val,
  input  logic [LOG_DEPTH_W:0]   free_cnt,
  output logic [LOG_DEPTH_W-1:0] tail,
  output logic [LOG_DEPTH_W:0]   occupancy,
  output logic                   has_space
);

  localparam logic [LOG_DEPTH_W:0] CAPACITY = {1'b1, {LOG_DEPTH_W{1'b0}}};

  logic [LOG_DEPTH_W:0] release_cnt;
  logic [LOG_DEPTH_W:0] occ_next;

  // Clamp the release to what is held, then combine with any same-cycle write
  always_comb begin
    release_cnt = '0;
    if (free_val) begin
      release_cnt = (free_cnt < occupancy) ? free_cnt : occupancy;
    end
    occ_next  = occupancy + (LOG_DEPTH_W+1)'(wr_acc) - release_cnt;
    has_space = (occupancy < CAPACITY);
  end

  // Tail wraps silently through the natural width of the register
  always_ff @(posedge clk) begin
    if (rst) begin
      tail      <= '0;
      occupancy <= '0;
    end else begin
      tail      <= tail + LOG_DEPTH_W'(wr_acc);
      occupancy <= occ_next;
    end
  end

endmodule

// File: rtl/log_mem_wr_arb.sv
// Round-robin write arbiter between the prepare and recovery engines onto
// the single log memory write port. A grant covers a whole entry (up to the
// last beat). Full-log policy is selected by LOG_ARB_DROP_ON_FULL_EN:
// undefined stalls the owner until space frees up; defined discards beats
// while full and counts dropped entries on arb_drop_cnt.
module log_mem_wr_arb
  import log_arb_pkg::*;
#(
  parameter int DATA_W      = 512,
  parameter int LOG_DEPTH_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prep_arb_wr_val,
  input  logic                   prep_arb_wr_last,
  input  logic [DATA_W-1:0]      prep_arb_wr_data,
  output logic                   arb_prep_wr_rdy,
  input  logic                   recov_arb_wr_val,
  input  logic                   recov_arb_wr_last,
  input  logic [DATA_W-1:0]      recov_arb_wr_data,
  output logic                   arb_recov_wr_rdy,
  output logic                   arb_log_mem_wr_val,
  output logic [LOG_DEPTH_W-1:0] arb_log_mem_wr_addr,
  output logic [DATA_W-1:0]      arb_log_mem_wr_data,
  input  logic                   log_mem_arb_wr_rdy,
  input  logic                   log_free_val,
  input  logic [LOG_DEPTH_W:0]   log_free_cnt,
  output logic                   arb_log_has_space,
  output logic [LOG_DEPTH_W:0]   arb_log_occupancy,
  output logic [LOG_DEPTH_W-1:0] arb_log_tail_addr
`ifdef LOG_ARB_DROP_ON_FULL_EN
  ,
  output logic [31:0]            arb_drop_cnt
`endif
);

  arb_state_e              state, state_next;
  logic                    rr_ptr, rr_next;
  logic                    own_val, own_last, own_rdy;
  logic [DATA_W-1:0]       own_data;
  logic                    mem_write, consume;
  logic                    has_space;
  logic [LOG_DEPTH_W-1:0]  tail;

  log_ptr_tracker #(.LOG_DEPTH_W(LOG_DEPTH_W)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .wr_acc    (mem_write && log_mem_arb_wr_rdy),
    .free_val  (log_free_val),
    .free_cnt  (log_free_cnt),
    .tail      (tail),
    .occupancy (arb_log_occupancy),
    .has_space (has_space)
  );

  // Arbitration, owner mux and handshake; reset suppresses every handshake
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    own_val    = 1'b0;
    own_last   = 1'b0;
    own_data   = '0;
    own_rdy    = 1'b0;
    mem_write  = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (prep_arb_wr_val && (!recov_arb_wr_val || rr_ptr == REQ_PREP)) begin
          state_next = GRANT_PREP;
        end else if (recov_arb_wr_val) begin
          state_next = GRANT_RECOV;
        end
      end
      GRANT_PREP: begin
        own_val  = prep_arb_wr_val;
        own_last = prep_arb_wr_last;
        own_data = prep_arb_wr_data;
      end
      GRANT_RECOV: begin
        own_val  = recov_arb_wr_val;
        own_last = recov_arb_wr_last;
        own_data = recov_arb_wr_data;
      end
      default: state_next = IDLE;
    endcase
    if (state == GRANT_PREP || state == GRANT_RECOV) begin
      if (has_space) begin
        own_rdy   = log_mem_arb_wr_rdy;
        mem_write = own_val;
      end
`ifdef LOG_ARB_DROP_ON_FULL_EN
      else begin
        own_rdy = 1'b1;
      end
`endif
      consume = own_val && own_rdy;
      if (consume && own_last) begin
        state_next = IDLE;
        rr_next    = (state == GRANT_PREP) ? REQ_RECOV : REQ_PREP;
      end
    end
    if (rst) begin
      own_rdy   = 1'b0;
      mem_write = 1'b0;
      consume   = 1'b0;
    end
  end

  assign arb_prep_wr_rdy     = own_rdy && (state == GRANT_PREP);
  assign arb_recov_wr_rdy    = own_rdy && (state == GRANT_RECOV);
  assign arb_log_mem_wr_val  = mem_write;
  assign arb_log_mem_wr_addr = tail;
  assign arb_log_mem_wr_data = own_data;
  assign arb_log_has_space   = has_space || rst;
  assign arb_log_tail_addr   = tail;

  // FSM state and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= REQ_PREP;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_next;
    end
  end

`ifdef LOG_ARB_DROP_ON_FULL_EN
  logic entry_dropped;

  // An entry counts as dropped once, at its last beat, if any beat was discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_drop_cnt  <= '0;
      entry_dropped <= 1'b0;
    end else if (consume) begin
      if (own_last) begin
        entry_dropped <= 1'b0;
        if ((entry_dropped || !has_space) && arb_drop_cnt != 32'hFFFF_FFFF) begin
          arb_drop_cnt <= arb_drop_cnt + 32'd1;
        end
      end else if (!has_space) begin
        entry_dropped <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_log_mem_wr_arb.sv
// Self-checking bench for log_mem_wr_arb (small log: 4 beats, 32-bit data).
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level reference model of the arbitration and log bookkeeping rules.
module tb_log_mem_wr_arb;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          prep_arb_wr_val, prep_arb_wr_last;
  logic [DW-1:0] prep_arb_wr_data;
  logic          arb_prep_wr_rdy;
  logic          recov_arb_wr_val, recov_arb_wr_last;
  logic [DW-1:0] recov_arb_wr_data;
  logic          arb_recov_wr_rdy;
  logic          arb_log_mem_wr_val;
  logic [AW-1:0] arb_log_mem_wr_addr;
  logic [DW-1:0] arb_log_mem_wr_data;
  logic          log_mem_arb_wr_rdy;
  logic          log_free_val;
  logic [AW:0]   log_free_cnt;
  logic          arb_log_has_space;
  logic [AW:0]   arb_log_occupancy;
  logic [AW-1:0] arb_log_tail_addr;
`ifdef LOG_ARB_DROP_ON_FULL_EN
  logic [31:0]   arb_drop_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: owner -1 none, 0 prep, 1 recov; rr 0 prep, 1 recov
  int m_occ, m_tail, m_owner, m_rr, m_drops;
  bit m_entry_dropped;

  always #5 clk = ~clk;

  log_mem_wr_arb #(.DATA_W(DW), .LOG_DEPTH_W(AW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .prep_arb_wr_val     (prep_arb_wr_val),
    .prep_arb_wr_last    (prep_arb_wr_last),
    .prep_arb_wr_data    (prep_arb_wr_data),
    .arb_prep_wr_rdy     (arb_prep_wr_rdy),
    .recov_arb_wr_val    (recov_arb_wr_val),
    .recov_arb_wr_last   (recov_arb_wr_last),
    .recov_arb_wr_data   (recov_arb_wr_data),
    .arb_recov_wr_rdy    (arb_recov_wr_rdy),
    .arb_log_mem_wr_val  (arb_log_mem_wr_val),
    .arb_log_mem_wr_addr (arb_log_mem_wr_addr),
    .arb_log_mem_wr_data (arb_log_mem_wr_data),
    .log_mem_arb_wr_rdy  (log_mem_arb_wr_rdy),
    .log_free_val        (log_free_val),
    .log_free_cnt        (log_free_cnt),
    .arb_log_has_space   (arb_log_has_space),
    .arb_log_occupancy   (arb_log_occupancy),
    .arb_log_tail_addr   (arb_log_tail_addr)
`ifdef LOG_ARB_DROP_ON_FULL_EN
    ,
    .arb_drop_cnt        (arb_drop_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model at the edge
  task automatic applyStimulus(input bit rs, input bit pv, input bit pl, input logic [DW-1:0] pd,
                               input bit rv, input bit rl, input logic [DW-1:0] rd,
                               input bit mr, input bit fv, input int fc);
    bit space, ov, ol, ordy, wv, consumed, written;
    logic [DW-1:0] od;
    int freed;
    rst = rs;
    prep_arb_wr_val = pv;  prep_arb_wr_last = pl;  prep_arb_wr_data = pd;
    recov_arb_wr_val = rv; recov_arb_wr_last = rl; recov_arb_wr_data = rd;
    log_mem_arb_wr_rdy = mr;
    log_free_val = fv;
    log_free_cnt = fc[AW:0];
    #1;
    space = (m_occ < DEPTH);
    ov = 1'b0; ol = 1'b0; od = '0; ordy = 1'b0; wv = 1'b0;
    if (!rs && m_owner >= 0) begin
      ov = (m_owner == 0) ? pv : rv;
      ol = (m_owner == 0) ? pl : rl;
      od = (m_owner == 0) ? pd : rd;
      if (space) begin
        ordy = mr;
        wv   = ov;
      end
`ifdef LOG_ARB_DROP_ON_FULL_EN
      else ordy = 1'b1;
`endif
    end
    checkOutput("prep_rdy",  arb_prep_wr_rdy,  (m_owner == 0) ? ordy : 1'b0);
    checkOutput("recov_rdy", arb_recov_wr_rdy, (m_owner == 1) ? ordy : 1'b0);
    checkOutput("wr_val",    arb_log_mem_wr_val, wv);
    checkOutput("has_space", arb_log_has_space, rs ? 1'b1 : space);
    if (!rs) begin
      checkOutput("occupancy", arb_log_occupancy, m_occ);
      checkOutput("tail",      arb_log_tail_addr, m_tail);
    end
    if (wv) begin
      checkOutput("wr_addr", arb_log_mem_wr_addr, m_tail);
      checkOutput("wr_data", arb_log_mem_wr_data, od);
    end
`ifdef LOG_ARB_DROP_ON_FULL_EN
    if (!rs) checkOutput("drop_cnt", arb_drop_cnt, m_drops);
`endif
    @(posedge clk);
    if (rs) begin
      m_occ = 0; m_tail = 0; m_owner = -1; m_rr = 0; m_drops = 0; m_entry_dropped = 0;
    end else begin
      consumed = (m_owner >= 0) && ov && ordy;
      written  = consumed && space;
      freed    = fv ? ((fc < m_occ) ? fc : m_occ) : 0;
      m_occ    = m_occ + int'(written) - freed;
      m_tail   = (m_tail + int'(written)) % DEPTH;
      if (consumed && !space) m_entry_dropped = 1;
      if (m_owner < 0) begin
        if (pv && (!rv || m_rr == 0)) m_owner = 0;
        else if (rv) m_owner = 1;
      end else if (consumed && ol) begin
        if (m_entry_dropped) m_drops++;
        m_entry_dropped = 0;
        m_rr    = 1 - m_owner;
        m_owner = -1;
      end
    end
    #1;
  endtask

  initial begin
    bit rs, pv, pl, rv, rl, mr, fv;
    int fc;
    m_owner = -1;

    // Reset behaviour, including outputs while rst is still high
    applyStimulus(1, 1, 0, 32'h0, 1, 0, 32'h0, 1, 0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("rst_occ", arb_log_occupancy, 0);
    checkOutput("rst_tail", arb_log_tail_addr, 0);

    // Lone prep 3-beat entry lands at addresses 0..2
    applyStimulus(0, 1, 0, 32'hA0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 0, 32'hA0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 0, 32'hA1, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'hA2, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("p3_occ", arb_log_occupancy, 3);
    checkOutput("p3_tail", arb_log_tail_addr, 3);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 3);
    checkOutput("p3_freed", arb_log_occupancy, 0);

    // Contention after reset: prep, then recov, then prep again
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'hB0, 1, 1, 32'hC0, 1, 0, 0);
    checkOutput("rr_prep_first", {arb_prep_wr_rdy, arb_recov_wr_rdy}, 2'b10);
    applyStimulus(0, 1, 1, 32'hB0, 1, 1, 32'hC0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'hB1, 1, 1, 32'hC0, 1, 0, 0);
    checkOutput("rr_recov_next", {arb_prep_wr_rdy, arb_recov_wr_rdy}, 2'b01);
    applyStimulus(0, 1, 1, 32'hB1, 1, 1, 32'hC0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'hB1, 1, 1, 32'hC1, 1, 0, 0);
    checkOutput("rr_prep_again", {arb_prep_wr_rdy, arb_recov_wr_rdy}, 2'b10);
    applyStimulus(0, 1, 1, 32'hB1, 1, 1, 32'hC1, 1, 0, 0);
    checkOutput("rr_occ", arb_log_occupancy, 3);

    // Same-cycle write and oversized free: 3 + 1 - 3 = 1, tail wraps 3 -> 0
    applyStimulus(0, 1, 1, 32'hB2, 1, 1, 32'hC2, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'hB2, 1, 1, 32'hC2, 1, 1, 5);
    checkOutput("wf_occ", arb_log_occupancy, 1);
    checkOutput("wf_tail", arb_log_tail_addr, 0);

    // Fill the log, stall the fifth beat, free two, then it writes at address 0
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 0, 32'hD0, 0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'hD0 + i, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("full_space", arb_log_has_space, 1'b0);
    checkOutput("full_occ", arb_log_occupancy, 4);
    applyStimulus(0, 1, 1, 32'hD4, 0, 0, 32'h0, 1, 0, 0);
`ifndef LOG_ARB_DROP_ON_FULL_EN
    checkOutput("full_stall_rdy", arb_prep_wr_rdy, 1'b0);
    applyStimulus(0, 1, 1, 32'hD4, 0, 0, 32'h0, 1, 1, 2);
    checkOutput("full_freed_occ", arb_log_occupancy, 2);
    checkOutput("full_resume_addr", {arb_log_mem_wr_val, arb_log_mem_wr_addr}, {1'b1, 2'd0});
    applyStimulus(0, 1, 1, 32'hD4, 0, 0, 32'h0, 1, 0, 0);
`endif

    // Reset in the middle of an entry abandons it
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 0, 32'hE0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 1, 0, 32'hE0, 0, 0, 32'h0, 1, 0, 0);
    applyStimulus(1, 1, 0, 32'hE1, 0, 0, 32'h0, 1, 0, 0);
    checkOutput("mid_rst_occ", arb_log_occupancy, 0);
    checkOutput("mid_rst_tail", arb_log_tail_addr, 0);
    checkOutput("mid_rst_wr", arb_log_mem_wr_val, 1'b0);
    applyStimulus(0, 1, 0, 32'hE1, 0, 0, 32'h0, 1, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 99) == 0);
      pv = ($urandom_range(0, 3) != 0);
      pl = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 2) == 0);
      mr = ($urandom_range(0, 4) != 0);
      fv = ($urandom_range(0, 4) == 0);
      fc = int'($urandom_range(0, 7));
      applyStimulus(rs, pv, pl, $urandom, rv, rl, $urandom, mr, fv, fc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
